// File: rtl/mux_n_to_1_arb.sv
// mux_n_to_1_arb: N-input registered selector with valid/ready handshake on every port.
// Define MUX_ROUND_ROBIN_EN to build round-robin arbitration (sel_mode = 1) and its pointer.
module mux_n_to_1_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               sel_mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] words [N];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;
    logic             load_en;
    logic             xfer;
    logic             fixed_vld;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            words[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // A select wide enough only for valid indices never needs the range check.
    if ((1 << SELW) <= N) begin : g_sel_full
        assign fixed_vld = 1'b1;
    end else begin : g_sel_part
        assign fixed_vld = (sel < SELW'(N));
    end

`ifdef MUX_ROUND_ROBIN_EN
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            rr_vld;
    logic [SELW-1:0] rr_idx;
    logic [SELW-1:0] rr_cand;

    always_comb begin
        rr_vld  = 1'b0;
        rr_idx  = '0;
        rr_cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            rr_cand = SELW'((int unsigned'(ptr_q) + k) % N);
            if (!rr_vld && in_valid[rr_cand]) begin
                rr_vld = 1'b1;
                rr_idx = rr_cand;
            end
        end
    end

    always_comb begin
        grant_vld = sel_mode ? rr_vld : fixed_vld;
        grant_idx = sel_mode ? rr_idx : sel;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer && sel_mode) begin
            ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_sel_mode;
    assign unused_sel_mode = sel_mode;

    always_comb begin
        grant_vld = fixed_vld;
        grant_idx = sel;
    end
`endif

    assign load_en = !out_valid_q || out_ready;
    assign xfer    = !Reset && load_en && grant_vld && in_valid[grant_idx];

    always_comb begin
        in_ready = '0;
        if (!Reset && load_en && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // An empty load slot drops out_valid but keeps the last word and source visible.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = words[grant_idx];
                out_src_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_to_1_arb.sv
// Self-checking bench for mux_n_to_1_arb: directed scenarios plus randomized traffic
// against a cycle-level reference model of the selector and its output register.
`timescale 1ns/1ps
module tb_mux_n_to_1_arb;
    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int SELW  = 2;
`ifdef MUX_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic               Clk;
    logic               Reset;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               sel_mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_src;
    logic               out_valid;
    logic               out_ready;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] m_data;
    logic [SELW-1:0]  m_src;
    bit               m_valid;
    int               m_ptr;

    mux_n_to_1_arb #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel_mode(sel_mode), .sel(sel), .out_data(out_data),
        .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void model_reset();
        m_data  = '0;
        m_src   = '0;
        m_valid = 1'b0;
        m_ptr   = 0;
    endfunction

    // Round robin picks the valid input at the smallest circular distance from the pointer.
    function automatic int model_grant();
        int best  = -1;
        int bestd = N;
        if (!RR || !sel_mode) return (int'(sel) < N) ? int'(sel) : -1;
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && ((i - m_ptr + N) % N) < bestd) begin
                best  = i;
                bestd = (i - m_ptr + N) % N;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g = model_grant();
        if (Reset || g < 0 || !(!m_valid || out_ready)) return '0;
        return N'(1) << g;
    endfunction

    task automatic set_word(input int i, input logic [WIDTH-1:0] v);
        in_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic tick();
        int g;
        bit load;
        g    = model_grant();
        load = !m_valid || out_ready;
        @(posedge Clk);
        if (load) begin
            if (g >= 0 && in_valid[g]) begin
                m_data  = in_data[g*WIDTH +: WIDTH];
                m_src   = g[SELW-1:0];
                m_valid = 1'b1;
                if (RR && sel_mode) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0 || in_ready !== '0) begin
            fails++;
            $display("FAIL reset_initial: valid=%b data=%h src=%0d ready=%b, want 0/0/0/0000",
                     out_valid, out_data, out_src, in_ready);
        end
        Reset = 1'b0;
        sel = 2'd1;
        set_word(1, 32'hA5A5_0001);
        out_ready = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) begin
            fails++;
            $display("FAIL reset_preload: valid=%b data=%h, want 1/a5a50001", out_valid, out_data);
        end
        #1 Reset = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0 || in_ready !== '0) begin
            fails++;
            $display("FAIL reset_async: valid=%b data=%h src=%0d ready=%b, want 0/0/0/0000",
                     out_valid, out_data, out_src, in_ready);
        end
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || out_src !== 2'd1) begin
            fails++;
            $display("FAIL reset_first_xfer: valid=%b data=%h src=%0d, want 1/a5a50001/1",
                     out_valid, out_data, out_src);
        end
    endtask

    task automatic test_fixed();
        @(negedge Clk);
        sel_mode = 1'b0;
        sel = 2'd2;
        in_valid = 4'b1111;
        set_word(2, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 4'b0100) begin
            fails++;
            $display("FAIL fixed_ready: in_ready=%b, want 0100", in_ready);
        end
        tick();
        tests++;
        if (out_data !== 32'hDEAD_BEEF || out_src !== 2'd2 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL fixed_out: data=%h src=%0d valid=%b, want deadbeef/2/1",
                     out_data, out_src, out_valid);
        end
    endtask

    task automatic test_back_pressure();
        @(negedge Clk);
        out_ready = 1'b0;
        in_valid = 4'b1111;
        sel = 2'd0;
        set_word(0, 32'h1234_5678);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (in_ready !== '0) begin
                fails++;
                $display("FAIL bp_ready[%0d]: in_ready=%b, want 0000", c, in_ready);
            end
            tick();
            tests++;
            if (out_data !== 32'hDEAD_BEEF || out_valid !== 1'b1 || out_src !== 2'd2) begin
                fails++;
                $display("FAIL bp_hold[%0d]: data=%h valid=%b src=%0d, want deadbeef/1/2",
                         c, out_data, out_valid, out_src);
            end
            @(negedge Clk);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 4'b0001) begin
            fails++;
            $display("FAIL bp_release_ready: in_ready=%b, want 0001", in_ready);
        end
        tick();
        tests++;
        if (out_data !== 32'h1234_5678 || out_src !== 2'd0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_out: data=%h src=%0d valid=%b, want 12345678/0/1",
                     out_data, out_src, out_valid);
        end
    endtask

`ifdef MUX_ROUND_ROBIN_EN
    task automatic test_rr_fairness();
        reset_pulse();
        sel_mode = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            tests++;
            if (out_src !== SELW'(k % N) || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL rr_fair[%0d]: src=%0d valid=%b, want %0d/1",
                         k, out_src, out_valid, k % N);
            end
        end
    endtask

    task automatic test_rr_skip_wrap();
        reset_pulse();
        sel_mode = 1'b1;
        out_ready = 1'b1;
        in_valid = 4'b0100;
        tick();
        @(negedge Clk);
        in_valid = 4'b0010;
        #1;
        tests++;
        if (in_ready !== 4'b0010) begin
            fails++;
            $display("FAIL rr_skip_ready: in_ready=%b, want 0010", in_ready);
        end
        tick();
        tests++;
        if (out_src !== 2'd1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL rr_skip_src: src=%0d valid=%b, want 1/1", out_src, out_valid);
        end
        @(negedge Clk);
        in_valid = 4'b1111;
        #1;
        tests++;
        if (in_ready !== 4'b0100) begin
            fails++;
            $display("FAIL rr_ptr_after_wrap: in_ready=%b, want 0100", in_ready);
        end
        tick();
    endtask
`else
    task automatic test_fixed_only();
        @(negedge Clk);
        sel_mode = 1'b1;
        sel = 2'd3;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_word(3, 32'hC0DE_0000 + k);
            #1;
            tests++;
            if (in_ready !== 4'b1000) begin
                fails++;
                $display("FAIL fixed_only_ready[%0d]: in_ready=%b, want 1000", k, in_ready);
            end
            tick();
            tests++;
            if (out_src !== 2'd3 || out_valid !== 1'b1 || out_data !== 32'hC0DE_0000 + k) begin
                fails++;
                $display("FAIL fixed_only_out[%0d]: src=%0d valid=%b data=%h, want 3/1/%h",
                         k, out_src, out_valid, out_data, 32'hC0DE_0000 + k);
            end
            @(negedge Clk);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge Clk);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            sel_mode  = ($urandom_range(0, 3) != 0);
            sel       = SELW'($urandom);
            for (int i = 0; i < N; i++) set_word(i, $urandom);
            #1;
            tests++;
            if (in_ready !== model_ready()) begin
                fails++;
                $display("FAIL rand_ready[%0d]: in_ready=%b, want %b", c, in_ready, model_ready());
            end
            tick();
            tests++;
            if (out_valid !== m_valid || out_data !== m_data || out_src !== m_src) begin
                fails++;
                $display("FAIL rand_out[%0d]: valid=%b data=%h src=%0d, want %b/%h/%0d",
                         c, out_valid, out_data, out_src, m_valid, m_data, m_src);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        in_data = '0;
        in_valid = 4'b1111;
        sel_mode = 1'b0;
        sel = 2'd1;
        out_ready = 1'b1;
        model_reset();
        test_reset();
        test_fixed();
        test_back_pressure();
`ifdef MUX_ROUND_ROBIN_EN
        test_rr_fairness();
        test_rr_skip_wrap();
`else
        test_fixed_only();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule
